// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue
// Description : Write-back queue in front of the GPR file. Buffers completed
//               results in a circular FIFO, retires one per cycle through the
//               file's single write port, and forwards the youngest pending
//               value for two read indices.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_queue #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4   // power of two, at least 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_addr,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       drain_hold,
    output logic                       rf_wen,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    input  logic [ADDR_WIDTH-1:0]      rs1_addr,
    input  logic [ADDR_WIDTH-1:0]      rs2_addr,
    output logic                       rs1_hit,
    output logic                       rs2_hit,
    output logic [DATA_WIDTH-1:0]      rs1_fwd,
    output logic [DATA_WIDTH-1:0]      rs2_fwd,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_PORTS = 2;

    // Entry storage; validity is implied by head/count, so it needs no reset.
    logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];

    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_nonempty;

    logic [ADDR_WIDTH-1:0] w_lk_addr [c_PORTS];
    logic                  w_lk_hit  [c_PORTS];
    logic [DATA_WIDTH-1:0] w_lk_data [c_PORTS];

    // Ready depends only on the registered count, so a pop in a full cycle
    // cannot open the input in that same cycle.
    assign in_ready   = (r_count < c_CNT_W'(DEPTH));
    assign w_nonempty = (r_count != '0);

    // Writes to x0 are accepted but never stored.
    assign w_push = in_valid && in_ready && (in_addr != '0);

    // A reset cycle must not commit a pending entry to the file.
    assign rf_wen   = rst_n && w_nonempty && !drain_hold;
    assign w_pop    = rf_wen;
    assign rf_waddr = w_nonempty ? r_addr_mem[r_head] : '0;
    assign rf_wdata = w_nonempty ? r_data_mem[r_head] : '0;
    assign count    = r_count;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Capture an accepted result at the tail slot.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_tail] <= in_addr;
            r_data_mem[r_tail] <= in_data;
        end
    end

    assign w_lk_addr[0] = rs1_addr;
    assign w_lk_addr[1] = rs2_addr;

    // One forwarding search per read port over the registered entries only;
    // the head is included even while it is being written this cycle.
    generate
        for (genvar p = 0; p < c_PORTS; p++) begin : g_fwd
            logic [c_PTR_W-1:0] w_idx;

            // Walk oldest to youngest so the last match is the youngest one.
            always_comb begin
                w_lk_hit[p]  = 1'b0;
                w_lk_data[p] = '0;
                w_idx        = r_head;
                for (int k = 0; k < DEPTH; k++) begin
                    w_idx = r_head + c_PTR_W'(k);
                    if ((c_CNT_W'(k) < r_count) &&
                        (w_lk_addr[p] != '0) &&
                        (r_addr_mem[w_idx] == w_lk_addr[p])) begin
                        w_lk_hit[p]  = 1'b1;
                        w_lk_data[p] = r_data_mem[w_idx];
                    end
                end
            end
        end
    endgenerate

    assign rs1_hit = rst_n && w_lk_hit[0];
    assign rs2_hit = rst_n && w_lk_hit[1];
    assign rs1_fwd = rs1_hit ? w_lk_data[0] : '0;
    assign rs2_fwd = rs2_hit ? w_lk_data[1] : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_queue
// Description : Self-checking bench for wb_queue. Stimulus updates an
//               in-order list model of pending results and pushes expected
//               file writes into a scoreboard; a monitor pops and compares
//               whenever the DUT asserts rf_wen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        drain_hold;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_hit;
    logic        rs2_hit;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;
    logic [2:0]  count;

    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    ent_t model_q[$];   // pending results, oldest first
    ent_t exp_q[$];     // expected file writes, in order

    wb_queue #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .drain_hold(drain_hold),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_hit(rs1_hit), .rs2_hit(rs2_hit),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Youngest pending value for an index; x0 never hits.
    function automatic void lookup(input logic [4:0] ra, output bit h, output logic [31:0] f);
        h = 1'b0;
        f = '0;
        if (ra != 5'd0) begin
            foreach (model_q[i]) begin
                if (model_q[i].a == ra) begin
                    h = 1'b1;
                    f = model_q[i].d;
                end
            end
        end
    endfunction

    // One clock cycle: drive, check at negedge, update the model after the edge.
    task automatic step(input bit v, input logic [4:0] a, input logic [31:0] d,
                        input bit hold, input bit rst,
                        input logic [4:0] r1, input logic [4:0] r2, input bit chk);
        bit          exp_ready, exp_wen, acc, h1, h2;
        logic [31:0] f1, f2;
        ent_t        e;
        in_valid   = v;
        in_addr    = a;
        in_data    = d;
        drain_hold = hold;
        rst_n      = !rst;
        rs1_addr   = r1;
        rs2_addr   = r2;
        @(negedge clk);
        exp_ready = (model_q.size() < DEPTH);
        exp_wen   = !rst && (model_q.size() != 0) && !hold;
        lookup(r1, h1, f1);
        lookup(r2, h2, f2);
        if (rst) begin
            h1 = 1'b0; f1 = '0; h2 = 1'b0; f2 = '0;
        end
        if (chk) begin
            check("count",    32'(count),    32'(model_q.size()));
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("rf_wen",   32'(rf_wen),   32'(exp_wen));
            check("rs1_hit",  32'(rs1_hit),  32'(h1));
            check("rs1_fwd",  rs1_fwd,       f1);
            check("rs2_hit",  32'(rs2_hit),  32'(h2));
            check("rs2_fwd",  rs2_fwd,       f2);
        end
        acc = v && exp_ready && !rst && (a != 5'd0);
        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
            exp_q.delete();
        end else begin
            if (exp_wen) void'(model_q.pop_front());
            if (acc) begin
                e.a = a;
                e.d = d;
                model_q.push_back(e);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input bit hold, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, hold, 1'b0, 5'd0, 5'd0, 1'b1);
    endtask

    // Scoreboard monitor: every file write must match the oldest expected one.
    always @(negedge clk) begin
        if (mon_en && rf_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rf_write: got (%0d,0x%0h) expected no write at %0t", rf_waddr, rf_wdata, $time);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                check("rf_waddr", 32'(rf_waddr), 32'(e.a));
                check("rf_wdata", rf_wdata, e.d);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 2000000 expected finish earlier");
        $fatal(1);
    end

    initial begin
        // Reset: the first cycle leaves state unknown, the second is checked.
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd3, 5'd0, 1'b1);
        mon_en = 1'b1;
        idle(1'b0, 1);

        // Fill under drain_hold, then forward the youngest of two index-3 entries.
        step(1'b1, 5'd3, 32'hA, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1);
        step(1'b1, 5'd3, 32'hB, 1'b1, 1'b0, 5'd3, 5'd0, 1'b1);
        step(1'b1, 5'd7, 32'hC, 1'b1, 1'b0, 5'd3, 5'd7, 1'b1);
        step(1'b1, 5'd9, 32'hD, 1'b1, 1'b0, 5'd9, 5'd3, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd3, 5'd7, 1'b1);
        // Release: four consecutive writes in arrival order.
        for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd9, 1'b1);

        // x0 result is dropped.
        step(1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1);

        // Streaming: push every cycle, pointers wrap several times.
        for (int i = 0; i < 10; i++)
            step(1'b1, 5'(i + 1), $urandom, 1'b0, 1'b0, 5'(i), 5'(i + 1), 1'b1);
        idle(1'b0, 2);

        // Reset with three pending entries and an offer in the reset cycle.
        step(1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1);
        step(1'b1, 5'd5, 32'h45, 1'b1, 1'b0, 5'd4, 5'd0, 1'b1);
        step(1'b1, 5'd6, 32'h46, 1'b1, 1'b0, 5'd4, 5'd5, 1'b1);
        step(1'b1, 5'd8, 32'h48, 1'b0, 1'b1, 5'd4, 5'd6, 1'b1);
        idle(1'b0, 3);

        // Full queue with drain released: refuse, pop, then accept next cycle.
        for (int i = 0; i < 4; i++) step(1'b1, 5'(10 + i), 32'(100 + i), 1'b1, 1'b0, 5'd0, 5'd0, 1'b1);
        step(1'b1, 5'd20, 32'h200, 1'b0, 1'b0, 5'd10, 5'd13, 1'b1);
        step(1'b1, 5'd20, 32'h200, 1'b1, 1'b0, 5'd20, 5'd11, 1'b1);
        idle(1'b1, 1);
        idle(1'b0, 6);

        // Randomized traffic with small index range to exercise forwarding.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 70, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 2,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'b1);
        end
        idle(1'b0, 8);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
